// File: rtl/rr_arb_8.sv
// 8-way round-robin arbiter with registered one-hot grant, binary index and valid.
// Optional hold timeout is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arb_8 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic       win_found;
  logic [2:0] win_id;

  // Scan upward from ptr, wrapping 7->0; the first set request wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = ptr + 3'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |8'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state     <= GRANT;
            gnt       <= 8'b1 << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // A release (or disable) wins over a timeout on the same edge.
          if (!en || !req[gnt_id]) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 3'd1;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_8.sv
// Scoreboard bench for rr_arb_8: a behavioural model pushes expected outputs per
// driven cycle; they are popped and compared one edge later.
module tb_rr_arb_8;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'd0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  rr_arb_8 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state
  logic       m_valid;
  logic [2:0] m_id;
  logic [2:0] m_ptr;
  int         m_cnt;
  logic       m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 3'd0;
    m_ptr   = 3'd0;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    m_to = 1'b0;
    if (!m_valid) begin
      if (e && r != 8'd0) begin
        for (int i = 0; i < 8; i++) begin
          int k;
          k = (int'(m_ptr) + i) % 8;
          if (!m_valid && r[k]) begin
            m_valid = 1'b1;
            m_id    = 3'(k);
            m_cnt   = 1;
          end
        end
      end
    end else if (!e || !r[m_id]) begin
      m_valid = 1'b0;
      m_ptr   = m_id + 3'd1;
      m_id    = 3'd0;
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      if (m_cnt >= TO) begin
        m_valid = 1'b0;
        m_ptr   = m_id + 3'd1;
        m_id    = 3'd0;
        m_to    = 1'b1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic check_onehot();
    check("onehot", 32'($onehot0(gnt)), 32'd1);
    check("gnt_vs_id", 32'(gnt), gnt_valid ? 32'(8'b1 << gnt_id) : 32'd0);
  endtask

  task automatic step(input logic [7:0] r, input logic e);
    exp_t x;
    @(negedge clk);
    req = r;
    en  = e;
    model_step(r, e);
    x.gnt   = m_valid ? (8'b1 << m_id) : 8'd0;
    x.id    = m_valid ? m_id : 3'd0;
    x.valid = m_valid;
    x.to    = m_to;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("gnt", 32'(gnt), 32'(x.gnt));
    check("gnt_id", 32'(gnt_id), 32'(x.id));
    check("gnt_valid", 32'(gnt_valid), 32'(x.valid));
    check("timeout", 32'(timeout), 32'(x.to));
    check_onehot();
  endtask

  initial begin
    logic [7:0] r;
    model_reset();
    #12;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Basic grant from index 0, then wrap to 7
    step(8'h81, 1'b1);
    check("first_id0", 32'(gnt_id), 32'd0);
    step(8'h80, 1'b1);
    step(8'h80, 1'b1);
    check("then_id7", 32'(gnt_id), 32'd7);

    // Strict rotation with all requesting
    for (int k = 0; k < 8; k++) begin
      step(8'hFF & ~(8'b1 << ((k + 7) % 8)), 1'b1);
      step(8'hFF, 1'b1);
      check("rotate", 32'(gnt_id), 32'(k));
    end
    step(8'h00, 1'b1);

    // Enable gating and revoke, ptr moves to 5
    step(8'h10, 1'b0);
    step(8'h10, 1'b0);
    step(8'h10, 1'b1);
    check("en_grant", 32'(gnt), 32'h10);
    step(8'h10, 1'b1);
    step(8'h10, 1'b0);
    step(8'hFF, 1'b1);
    check("ptr5", 32'(gnt_id), 32'd5);
    step(8'h00, 1'b1);

    // Async reset mid-grant
    step(8'h04, 1'b1);
    step(8'h04, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(gnt_valid), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    step(8'h06, 1'b1);
    check("post_rst_id1", 32'(gnt_id), 32'd1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // Hold timeout (or unbounded hold when compiled out)
    model_reset();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(8'h03, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // Release on the timeout edge: release wins
    for (int i = 0; i < TO; i++) step(8'h08, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // Random traffic with sticky requests
    r = 8'h5A;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom);
      step(r, $urandom_range(9) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_8.md
RR_ARB_8 -- requirements
Module: rr_arb_8

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, range 1..255: maximum grant hold length in cycles; used only when RR_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  arbiter enable; 0 blocks new grants and revokes any current grant.
REQ-005 req  input  8  request vector; requester k holds req[k]=1 for as long as it needs the shared 8-to-3 encoder.
REQ-006 gnt  output  8  one-hot grant, registered; all zeros when no grant is active.
REQ-007 gnt_id  output  3  binary index of the granted requester, registered; 0 when gnt_valid=0.
REQ-008 gnt_valid  output  1  registered; 1 while a grant is active; equals OR of gnt.
REQ-009 timeout  output  1  one-cycle pulse on a forced revoke due to hold timeout; constant 0 when the feature is compiled out.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant active).
REQ-011 IDLE: if en=1 and req!=0 at a rising edge, the FSM SHALL go to GRANT, and gnt, gnt_id and gnt_valid SHALL reflect the winner from that edge (1-cycle latency from sampled req).
REQ-012 Winner selection SHALL be round-robin: the first set req bit found scanning upward from index ptr, wrapping 7->0.
REQ-013 ptr SHALL be a 3-bit register; on every grant end it SHALL load (gnt_id+1) mod 8; 7 wraps to 0.
REQ-014 In IDLE with en=0 or req=0, the FSM SHALL stay in IDLE and outputs SHALL stay 0.
REQ-015 GRANT: the grant SHALL be held unchanged while req[gnt_id]=1 and en=1; changes on other req bits SHALL be ignored.
REQ-016 When req[gnt_id]=0 at an edge, the FSM SHALL go to IDLE, clear gnt/gnt_id/gnt_valid, and advance ptr.
REQ-017 When en=0 at an edge in GRANT, the grant SHALL be revoked exactly as in REQ-016; en has priority over req.
REQ-018 After any grant end, at least one cycle with gnt_valid=0 SHALL occur before the next grant (the IDLE cycle samples req).
REQ-019 At most one gnt bit SHALL ever be 1, and gnt SHALL equal 1<<gnt_id whenever gnt_valid=1.
REQ-020 A requester that deasserts req in the same cycle it would be granted SHALL NOT be granted, because req is sampled at the edge.

Reset
REQ-021 While rst_n=0, the block SHALL force state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0, independent of clk.
REQ-022 Reset asserted in GRANT SHALL drop the grant immediately and asynchronously; the first grant after reset release SHALL start its scan from index 0.

Configuration
REQ-023 Macro RR_ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT; when it reaches TIMEOUT_CYCLES with the grant still requested, the grant SHALL be revoked as in REQ-016, and timeout SHALL pulse high for the cycle in which gnt_valid first returns to 0.
REQ-024 Macro RR_ARB_TIMEOUT_EN undefined: no counter SHALL be built, grants SHALL be unbounded, and timeout SHALL be tied to 0.
REQ-025 If a release and a timeout occur on the same edge, the release SHALL take precedence and timeout SHALL NOT pulse.

Verification
REQ-026 Reset, en=1, req=8'h81 held -> gnt=8'h01, gnt_id=0 one cycle after sampling; drop req[0] -> one idle cycle, then gnt=8'h80, gnt_id=7.
REQ-027 After gnt_id=7 releases with req=8'hFF -> ptr wraps; next gnt_id=0, then 1, 2, ... in strict rotation.
REQ-028 en=0 with req=8'h10 -> gnt stays 0; set en=1 -> gnt=8'h10 next cycle; clear en mid-grant -> gnt=0 next cycle, ptr=5.
REQ-029 req=8'h04 granted; assert rst_n=0 between clock edges -> gnt=0 immediately; after release, req=8'h06 -> gnt_id=1.
REQ-030 With RR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, req=8'h03 held -> gnt_id=0 for 4 cycles, timeout pulses once, then gnt_id=1; without the macro -> gnt_id=0 held indefinitely and timeout=0.
REQ-031 All scenarios -> continuous check that gnt is one-hot or zero and gnt==(gnt_valid ? 1<<gnt_id : 0).
